// File: rtl/ysyx_22050550_hazard_ctrl.sv
// ysyx_22050550_hazard_ctrl
// Register-hazard scoreboard between IDU and the WBU bypass path of a
// single-issue in-order pipeline. Each architectural register x1..x31 has a
// 2-bit count of in-flight writers (0..3). x0 is never tracked.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   io_IDU_valid                 IDU holds a decoded instruction
//   io_IDU_raddr1/2, ren1/2      source indices and their use flags
//   io_IDU_wen, io_IDU_waddr     destination write enable and index
//   io_IDU_ready                 issue allowed this cycle (issue = valid & ready)
//   io_IDU_pass1/2               operand must take the WBU bypass value
//   io_WBU_valid/wen/waddr       instruction retiring in WBU this cycle
//   io_flush                     squash everything in flight and in IDU
//   io_busy                      some register has a pending writer
//   io_err                       sticky: retire seen with a zero count
//   io_stall_cnt                 cycles IDU was valid but not ready
module ysyx_22050550_hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_IDU_valid,
    input  logic [4:0]  io_IDU_raddr1,
    input  logic [4:0]  io_IDU_raddr2,
    input  logic        io_IDU_ren1,
    input  logic        io_IDU_ren2,
    input  logic        io_IDU_wen,
    input  logic [4:0]  io_IDU_waddr,
    output logic        io_IDU_ready,
    output logic        io_IDU_pass1,
    output logic        io_IDU_pass2,
    input  logic        io_WBU_valid,
    input  logic        io_WBU_wen,
    input  logic [4:0]  io_WBU_waddr,
    input  logic        io_flush,
    output logic        io_busy,
    output logic        io_err,
    output logic [31:0] io_stall_cnt
);

    logic [31:0][1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      stall_q, stall_d;

    logic       wb_ret;
    logic [1:0] cnt_r1, cnt_r2, cnt_w, cnt_wb;
    logic       use1, use2;
    logic       ret_r1, ret_r2, ret_w;
    logic       hazard1, hazard2, wfull;
    logic       issue, same_reg;

    // wb_ret already excludes x0, so the per-operand retire matches below
    // never fire for index 0.
    assign wb_ret = io_WBU_valid & io_WBU_wen & (io_WBU_waddr != 5'd0);

    assign cnt_r1 = cnt_q[io_IDU_raddr1];
    assign cnt_r2 = cnt_q[io_IDU_raddr2];
    assign cnt_w  = cnt_q[io_IDU_waddr];
    assign cnt_wb = cnt_q[io_WBU_waddr];

    assign use1 = io_IDU_ren1 & (io_IDU_raddr1 != 5'd0);
    assign use2 = io_IDU_ren2 & (io_IDU_raddr2 != 5'd0);

    assign ret_r1 = wb_ret & (io_WBU_waddr == io_IDU_raddr1);
    assign ret_r2 = wb_ret & (io_WBU_waddr == io_IDU_raddr2);
    assign ret_w  = wb_ret & (io_WBU_waddr == io_IDU_waddr);

    // A lone producer retiring this cycle is not a hazard: its value is on
    // the bypass path.
    assign hazard1 = use1 & (cnt_r1 != 2'd0) & ~((cnt_r1 == 2'd1) & ret_r1);
    assign hazard2 = use2 & (cnt_r2 != 2'd0) & ~((cnt_r2 == 2'd1) & ret_r2);

    // A full counter can still accept a writer when one retires alongside.
    assign wfull = io_IDU_wen & (io_IDU_waddr != 5'd0) & (cnt_w == 2'd3) & ~ret_w;

    assign io_IDU_ready = ~hazard1 & ~hazard2 & ~wfull & ~io_flush;
    assign io_IDU_pass1 = io_IDU_valid & use1 & (cnt_r1 == 2'd1) & ret_r1;
    assign io_IDU_pass2 = io_IDU_valid & use2 & (cnt_r2 == 2'd1) & ret_r2;

    // ready already carries ~io_flush, so a flush cycle never issues.
    assign issue    = io_IDU_valid & io_IDU_ready & io_IDU_wen & (io_IDU_waddr != 5'd0);
    assign same_reg = issue & wb_ret & (io_IDU_waddr == io_WBU_waddr);

    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall_d = stall_q;

        if (io_IDU_valid & ~io_IDU_ready & ~io_flush) begin
            stall_d = stall_q + 32'd1;
        end

        if (io_flush) begin
            cnt_d = '0;
        end else begin
            if (wb_ret & (cnt_wb == 2'd0)) begin
                err_d = 1'b1;
            end
            if (issue & ~same_reg) begin
                cnt_d[io_IDU_waddr] = cnt_w + 2'd1;
            end
            if (wb_ret & ~same_reg & (cnt_wb != 2'd0)) begin
                cnt_d[io_WBU_waddr] = cnt_wb - 2'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign io_busy      = (cnt_q != '0);
    assign io_err       = err_q;
    assign io_stall_cnt = stall_q;

endmodule

// File: tb/tb_ysyx_22050550_hazard_ctrl.sv
// Testbench for ysyx_22050550_hazard_ctrl. Each step drives one cycle of
// IDU/WBU/flush inputs and carries the outputs expected in that cycle
// (ready/pass from the current inputs, busy/err/stall from the state built
// by earlier cycles). Expectations go through a scoreboard queue.
module tb_ysyx_22050550_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic        io_IDU_valid;
    logic [4:0]  io_IDU_raddr1, io_IDU_raddr2;
    logic        io_IDU_ren1, io_IDU_ren2;
    logic        io_IDU_wen;
    logic [4:0]  io_IDU_waddr;
    logic        io_IDU_ready, io_IDU_pass1, io_IDU_pass2;
    logic        io_WBU_valid, io_WBU_wen;
    logic [4:0]  io_WBU_waddr;
    logic        io_flush;
    logic        io_busy, io_err;
    logic [31:0] io_stall_cnt;

    int total = 0;
    int bad   = 0;

    ysyx_22050550_hazard_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .io_IDU_valid (io_IDU_valid),
        .io_IDU_raddr1(io_IDU_raddr1),
        .io_IDU_raddr2(io_IDU_raddr2),
        .io_IDU_ren1  (io_IDU_ren1),
        .io_IDU_ren2  (io_IDU_ren2),
        .io_IDU_wen   (io_IDU_wen),
        .io_IDU_waddr (io_IDU_waddr),
        .io_IDU_ready (io_IDU_ready),
        .io_IDU_pass1 (io_IDU_pass1),
        .io_IDU_pass2 (io_IDU_pass2),
        .io_WBU_valid (io_WBU_valid),
        .io_WBU_wen   (io_WBU_wen),
        .io_WBU_waddr (io_WBU_waddr),
        .io_flush     (io_flush),
        .io_busy      (io_busy),
        .io_err       (io_err),
        .io_stall_cnt (io_stall_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        v;
        logic [4:0]  r1;
        logic        e1;
        logic [4:0]  r2;
        logic        e2;
        logic        w;
        logic [4:0]  wa;
        logic        bv;
        logic        bw;
        logic [4:0]  ba;
        logic        fl;
        logic        rdy;
        logic        p1;
        logic        p2;
        logic        busy;
        logic        err;
        logic [31:0] st;
    } step_t;

    step_t sb[$];

    function automatic step_t mk(input int v, input int r1, input int e1, input int r2, input int e2,
                                 input int w, input int wa, input int bv, input int bw, input int ba,
                                 input int fl, input int rdy, input int p1, input int p2,
                                 input int busy, input int err, input int st);
        step_t s;
        s.v    = (v != 0);
        s.r1   = 5'(r1);
        s.e1   = (e1 != 0);
        s.r2   = 5'(r2);
        s.e2   = (e2 != 0);
        s.w    = (w != 0);
        s.wa   = 5'(wa);
        s.bv   = (bv != 0);
        s.bw   = (bw != 0);
        s.ba   = 5'(ba);
        s.fl   = (fl != 0);
        s.rdy  = (rdy != 0);
        s.p1   = (p1 != 0);
        s.p2   = (p2 != 0);
        s.busy = (busy != 0);
        s.err  = (err != 0);
        s.st   = 32'(st);
        return s;
    endfunction

    task automatic drive(input step_t s);
        io_IDU_valid  = s.v;
        io_IDU_raddr1 = s.r1;
        io_IDU_ren1   = s.e1;
        io_IDU_raddr2 = s.r2;
        io_IDU_ren2   = s.e2;
        io_IDU_wen    = s.w;
        io_IDU_waddr  = s.wa;
        io_WBU_valid  = s.bv;
        io_WBU_wen    = s.bw;
        io_WBU_waddr  = s.ba;
        io_flush      = s.fl;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        #2;
        total++;
        if ({io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset flags rdy/p1/p2/busy/err got %b want 10000",
                     {io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err});
        end
        total++;
        if (io_stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset stall_cnt got %0d want 0", io_stall_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_issue_stall();
        step_t t[$];
        step_t e;
        t.push_back(mk(1,0,0,0,0,1,5,0,0,0,0, 1,0,0,0,0,0));
        t.push_back(mk(1,5,1,0,0,0,0,0,0,0,0, 0,0,0,1,0,0));
        t.push_back(mk(1,5,1,0,0,0,0,0,0,0,0, 0,0,0,1,0,1));
        t.push_back(mk(1,5,1,0,0,0,0,0,0,0,0, 0,0,0,1,0,2));
        foreach (t[k]) begin
            @(negedge clock);
            drive(t[k]);
            sb.push_back(t[k]);
            #1;
            e = sb.pop_front();
            total++;
            if ({io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err} !== {e.rdy, e.p1, e.p2, e.busy, e.err}) begin
                bad++;
                $display("FAIL issue_stall step %0d rdy/p1/p2/busy/err got %b want %b", k,
                         {io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err}, {e.rdy, e.p1, e.p2, e.busy, e.err});
            end
            total++;
            if (io_stall_cnt !== e.st) begin
                bad++;
                $display("FAIL issue_stall step %0d stall_cnt got %0d want %0d", k, io_stall_cnt, e.st);
            end
        end
    endtask

    task automatic test_bypass();
        step_t t[$];
        step_t e;
        t.push_back(mk(1,5,1,0,0,0,0,1,1,5,0, 1,1,0,1,0,3));
        t.push_back(mk(1,5,1,0,0,0,0,0,0,0,0, 1,0,0,0,0,3));
        foreach (t[k]) begin
            @(negedge clock);
            drive(t[k]);
            sb.push_back(t[k]);
            #1;
            e = sb.pop_front();
            total++;
            if ({io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err} !== {e.rdy, e.p1, e.p2, e.busy, e.err}) begin
                bad++;
                $display("FAIL bypass step %0d rdy/p1/p2/busy/err got %b want %b", k,
                         {io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err}, {e.rdy, e.p1, e.p2, e.busy, e.err});
            end
            total++;
            if (io_stall_cnt !== e.st) begin
                bad++;
                $display("FAIL bypass step %0d stall_cnt got %0d want %0d", k, io_stall_cnt, e.st);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t t[$];
        step_t e;
        t.push_back(mk(1,0,0,0,0,1,6,0,0,0,0, 1,0,0,0,0,3));
        t.push_back(mk(1,0,0,6,1,0,0,1,1,6,0, 1,0,1,1,0,3));
        t.push_back(mk(1,0,0,6,1,0,0,0,0,0,0, 1,0,0,0,0,3));
        t.push_back(mk(1,0,0,0,0,1,6,0,0,0,0, 1,0,0,0,0,3));
        t.push_back(mk(0,0,0,6,1,0,0,1,1,6,0, 1,0,0,1,0,3));
        t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,3));
        foreach (t[k]) begin
            @(negedge clock);
            drive(t[k]);
            sb.push_back(t[k]);
            #1;
            e = sb.pop_front();
            total++;
            if ({io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err} !== {e.rdy, e.p1, e.p2, e.busy, e.err}) begin
                bad++;
                $display("FAIL back_to_back step %0d rdy/p1/p2/busy/err got %b want %b", k,
                         {io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err}, {e.rdy, e.p1, e.p2, e.busy, e.err});
            end
            total++;
            if (io_stall_cnt !== e.st) begin
                bad++;
                $display("FAIL back_to_back step %0d stall_cnt got %0d want %0d", k, io_stall_cnt, e.st);
            end
        end
    endtask

    task automatic test_waw();
        step_t t[$];
        step_t e;
        t.push_back(mk(1,0,0,0,0,1,7,0,0,0,0, 1,0,0,0,0,3));
        t.push_back(mk(1,0,0,0,0,1,7,0,0,0,0, 1,0,0,1,0,3));
        t.push_back(mk(1,0,0,0,0,1,7,0,0,0,0, 1,0,0,1,0,3));
        t.push_back(mk(1,0,0,0,0,1,7,0,0,0,0, 0,0,0,1,0,3));
        t.push_back(mk(1,0,0,0,0,1,7,1,1,7,0, 1,0,0,1,0,4));
        t.push_back(mk(1,0,0,0,0,1,7,0,0,0,0, 0,0,0,1,0,4));
        t.push_back(mk(0,0,0,0,0,1,7,0,0,0,0, 0,0,0,1,0,5));
        t.push_back(mk(1,7,1,0,0,0,0,1,1,7,0, 0,0,0,1,0,5));
        t.push_back(mk(0,0,0,0,0,0,0,1,1,7,0, 1,0,0,1,0,6));
        t.push_back(mk(0,0,0,0,0,0,0,1,1,7,0, 1,0,0,1,0,6));
        t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,6));
        foreach (t[k]) begin
            @(negedge clock);
            drive(t[k]);
            sb.push_back(t[k]);
            #1;
            e = sb.pop_front();
            total++;
            if ({io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err} !== {e.rdy, e.p1, e.p2, e.busy, e.err}) begin
                bad++;
                $display("FAIL waw step %0d rdy/p1/p2/busy/err got %b want %b", k,
                         {io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err}, {e.rdy, e.p1, e.p2, e.busy, e.err});
            end
            total++;
            if (io_stall_cnt !== e.st) begin
                bad++;
                $display("FAIL waw step %0d stall_cnt got %0d want %0d", k, io_stall_cnt, e.st);
            end
        end
    endtask

    task automatic test_x0();
        step_t t[$];
        step_t e;
        t.push_back(mk(1,0,1,0,1,1,0,1,1,0,0, 1,0,0,0,0,6));
        t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,6));
        foreach (t[k]) begin
            @(negedge clock);
            drive(t[k]);
            sb.push_back(t[k]);
            #1;
            e = sb.pop_front();
            total++;
            if ({io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err} !== {e.rdy, e.p1, e.p2, e.busy, e.err}) begin
                bad++;
                $display("FAIL x0 step %0d rdy/p1/p2/busy/err got %b want %b", k,
                         {io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err}, {e.rdy, e.p1, e.p2, e.busy, e.err});
            end
            total++;
            if (io_stall_cnt !== e.st) begin
                bad++;
                $display("FAIL x0 step %0d stall_cnt got %0d want %0d", k, io_stall_cnt, e.st);
            end
        end
    endtask

    task automatic test_flush_err();
        step_t t[$];
        step_t e;
        t.push_back(mk(1,0,0,0,0,1,9,0,0,0,0, 1,0,0,0,0,6));
        t.push_back(mk(1,0,0,0,0,1,9,0,0,0,0, 1,0,0,1,0,6));
        t.push_back(mk(1,0,0,0,0,1,9,1,1,9,1, 0,0,0,1,0,6));
        t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,6));
        t.push_back(mk(0,0,0,0,0,0,0,1,1,9,0, 1,0,0,0,0,6));
        t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,1,6));
        t.push_back(mk(1,9,1,0,0,0,0,0,0,0,0, 1,0,0,0,1,6));
        foreach (t[k]) begin
            @(negedge clock);
            drive(t[k]);
            sb.push_back(t[k]);
            #1;
            e = sb.pop_front();
            total++;
            if ({io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err} !== {e.rdy, e.p1, e.p2, e.busy, e.err}) begin
                bad++;
                $display("FAIL flush_err step %0d rdy/p1/p2/busy/err got %b want %b", k,
                         {io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_err}, {e.rdy, e.p1, e.p2, e.busy, e.err});
            end
            total++;
            if (io_stall_cnt !== e.st) begin
                bad++;
                $display("FAIL flush_err step %0d stall_cnt got %0d want %0d", k, io_stall_cnt, e.st);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        drive(mk(1,0,0,0,0,1,3,0,0,0,0, 1,0,0,0,0,0));
        @(negedge clock);
        drive(mk(1,0,0,0,0,1,3,0,0,0,0, 1,0,0,0,0,0));
        @(negedge clock);
        drive(mk(1,3,1,0,0,0,0,0,0,0,0, 0,0,0,1,0,0));
        @(posedge clock);
        #2;
        total++;
        if ({io_IDU_ready, io_busy, io_err} !== 3'b011 || io_stall_cnt !== 32'd7) begin
            bad++;
            $display("FAIL async_pre rdy/busy/err got %b want 011, stall_cnt got %0d want 7",
                     {io_IDU_ready, io_busy, io_err}, io_stall_cnt);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({io_IDU_ready, io_IDU_pass1, io_busy, io_err} !== 4'b1000) begin
            bad++;
            $display("FAIL async_reset rdy/p1/busy/err got %b want 1000",
                     {io_IDU_ready, io_IDU_pass1, io_busy, io_err});
        end
        total++;
        if (io_stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL async_reset stall_cnt got %0d want 0", io_stall_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        @(negedge clock);
        #1;
        total++;
        if ({io_IDU_ready, io_busy, io_err} !== 3'b100 || io_stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL async_post rdy/busy/err got %b want 100, stall_cnt got %0d want 0",
                     {io_IDU_ready, io_busy, io_err}, io_stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_issue_stall();
        test_bypass();
        test_back_to_back();
        test_waw();
        test_x0();
        test_flush_err();
        test_async_reset();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain leftover got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
